// File: rtl/grn_pipe_pkg.sv
// Shared constants and types for the green pipe field of the Flappy Bird display.
package grn_pipe_pkg;

    // Display geometry
    localparam int N_COLS   = 16;
    localparam int N_ROWS   = 16;

    // Column watched by the collision logic (where the bird sits)
    localparam int BIRD_COL = 12;

    // One display column: bit r is row r
    typedef logic [N_ROWS-1:0] col_t;

    // Default pipe column: lit pixels everywhere except the gap in rows 6..9
    localparam col_t PIPE_PATTERN = 16'hFC3F;

    // Index of the column that feeds column c in the ring (column 0 is fed by the last one)
    function automatic int ring_prev(input int c, input int n_cols);
        return (c == 0) ? (n_cols - 1) : (c - 1);
    endfunction

endpackage

// File: rtl/grn_pipe_col.sv
// A single column register of the scrolling ring: reloads its reset image,
// takes its neighbour's value while the game runs, and holds while frozen.
module grn_pipe_col
    import grn_pipe_pkg::*;
#(
    parameter int           W         = N_ROWS,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         Over,
    input  logic [W-1:0] NR,
    output logic [W-1:0] lightOn
);

    logic [W-1:0] col_reg;

    // Reset wins over freeze; otherwise shift in the neighbour unless the game is over
    always_ff @(posedge clk) begin
        if (RST) begin
            col_reg <= RESET_VAL;
        end else if (!Over) begin
            col_reg <= NR;
        end
    end

    assign lightOn = col_reg;

endmodule

// File: rtl/grn_pipe_scroller.sv
// 16x16 green pipe field: a ring of column registers rotating one column per
// clock, frozen on game-over, with the bird's column exposed for collision.
module grn_pipe_scroller
    import grn_pipe_pkg::*;
#(
    parameter int                N_COLS       = grn_pipe_pkg::N_COLS,
    parameter int                N_ROWS       = grn_pipe_pkg::N_ROWS,
    parameter logic [N_ROWS-1:0] PIPE_PATTERN = grn_pipe_pkg::PIPE_PATTERN,
    parameter int                BIRD_COL     = grn_pipe_pkg::BIRD_COL
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic                           Over,
    output logic [N_COLS-1:0][N_ROWS-1:0]  GrnPixels,
    output logic [N_ROWS-1:0]              pipeState
);

    // Outputs of the column registers, one element per column
    logic [N_ROWS-1:0] col_q [N_COLS];

    // Build the ring: column gi takes column gi-1, column 0 takes the last column.
    // The pipe is two columns wide, so columns 0 and 1 power up with the pattern.
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
        localparam int                PREV  = ring_prev(gi, N_COLS);
        localparam logic [N_ROWS-1:0] R_VAL = (gi < 2) ? PIPE_PATTERN : '0;

        grn_pipe_col #(
            .W         (N_ROWS),
            .RESET_VAL (R_VAL)
        ) u_col (
            .clk     (clk),
            .RST     (RST),
            .Over    (Over),
            .NR      (col_q[PREV]),
            .lightOn (col_q[gi])
        );

        assign GrnPixels[gi] = col_q[gi];
    end

    // Zero-latency view of the bird's column for the collision logic
    assign pipeState = col_q[BIRD_COL];

endmodule

// File: tb/tb_grn_pipe_scroller.sv
// Self-checking bench for grn_pipe_scroller: a closed-form position model pushes
// the expected image per edge into a scoreboard queue, popped after each edge.
module tb_grn_pipe_scroller;

    localparam logic [15:0] PAT = 16'hFC3F;

    logic                  clk;
    logic                  RST;
    logic                  Over;
    logic [15:0][15:0]     GrnPixels;
    logic [15:0]           pipeState;

    grn_pipe_scroller dut (
        .clk       (clk),
        .RST       (RST),
        .Over      (Over),
        .GrnPixels (GrnPixels),
        .pipeState (pipeState)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] img;
        logic [15:0]  ps;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;   // scroll edges since last reset, modulo 16

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected image: the pipe sits in columns pos and pos+1 (mod 16)
    function automatic logic [255:0] image_at(input int pos);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == pos || c == ((pos + 1) % 16)) v[c*16 +: 16] = PAT;
        end
        return v;
    endfunction

    function automatic int popcount256(input logic [255:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) n += int'(v[i]);
        return n;
    endfunction

    // Drive one edge, push the expected result, then pop and compare after the edge
    task automatic step(input logic rst, input logic over);
        exp_t e;
        RST  = rst;
        Over = over;
        if (rst)        k = 0;
        else if (!over) k = (k + 1) % 16;
        e.img = image_at(k);
        e.ps  = (k == 11 || k == 12) ? PAT : 16'h0000;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("image", GrnPixels, e.img);
        check_eq("pipeState", {240'd0, pipeState}, {240'd0, e.ps});
        check_eq("popcount", 256'(popcount256(GrnPixels)), 256'd24);
        $display("edge RST=%0b Over=%0b k=%0d pipeState=%h", rst, over, k, pipeState);
    endtask

    logic [255:0] reset_img;
    logic [255:0] snap;

    initial begin
        clk  = 1'b0;
        RST  = 1'b1;
        Over = 1'b0;
        reset_img = '0;
        reset_img[15:0]  = PAT;
        reset_img[31:16] = PAT;

        // Reset image
        step(1'b1, 1'b0);
        check_eq("rst_col0", {240'd0, GrnPixels[0]}, {240'd0, PAT});
        check_eq("rst_col1", {240'd0, GrnPixels[1]}, {240'd0, PAT});
        check_eq("rst_image", GrnPixels, reset_img);
        check_eq("rst_pipeState", {240'd0, pipeState}, 256'd0);

        // Scroll timing: pipe reaches the bird column after 11 edges
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0);
        check_eq("k11_col11", {240'd0, GrnPixels[11]}, {240'd0, PAT});
        check_eq("k11_col12", {240'd0, GrnPixels[12]}, {240'd0, PAT});
        check_eq("k11_pipeState", {240'd0, pipeState}, {240'd0, PAT});
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        check_eq("k13_pipeState", {240'd0, pipeState}, 256'd0);

        // Wrap-around
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        check_eq("k15_col15", {240'd0, GrnPixels[15]}, {240'd0, PAT});
        check_eq("k15_col0", {240'd0, GrnPixels[0]}, {240'd0, PAT});
        step(1'b0, 1'b0);
        check_eq("k16_image", GrnPixels, reset_img);

        // 32 full periods: image returns to the reset image every 16 edges
        for (int p = 0; p < 32; p++) begin
            for (int i = 0; i < 16; i++) step(1'b0, 1'b0);
            check_eq("period_image", GrnPixels, reset_img);
        end

        // Freeze: pipe in cols 5,6 holds for 10 edges, then resumes to cols 6,7
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        snap = GrnPixels;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            check_eq("freeze_hold", GrnPixels, snap);
        end
        check_eq("freeze_col5", {240'd0, GrnPixels[5]}, {240'd0, PAT});
        step(1'b0, 1'b0);
        check_eq("resume_col6", {240'd0, GrnPixels[6]}, {240'd0, PAT});
        check_eq("resume_col7", {240'd0, GrnPixels[7]}, {240'd0, PAT});
        check_eq("resume_col5", {240'd0, GrnPixels[5]}, 256'd0);

        // Reset while frozen has priority, then one scroll puts pipe in cols 1,2
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_eq("rst_over_image", GrnPixels, reset_img);
        step(1'b0, 1'b0);
        check_eq("post_rst_col1", {240'd0, GrnPixels[1]}, {240'd0, PAT});
        check_eq("post_rst_col2", {240'd0, GrnPixels[2]}, {240'd0, PAT});
        check_eq("post_rst_col0", {240'd0, GrnPixels[0]}, 256'd0);

        // Reset mid-scroll leaves no residual pixels
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_eq("mid_rst_image", GrnPixels, reset_img);

        // Random Over pattern against the model
        for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
